// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-wide RAM arbiter between IF (read) and MEM (load/store)
//
// Purpose: grants one single-port byte RAM to IF or MEM with a zero-cycle grant,
//   locks the winner until it drops its request, and returns read bytes one
//   cycle after the address on a shared data bus.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   if_request/if_addr  IF read request and byte address
//   mem_request         00 none, 01 load, 10 store, 11 treated as none
//   mem_addr            MEM byte address
//   mem_ctrl_data_i     MEM store byte
//   if_or_mem           current owner: 00 none, 01 IF, 10 MEM
//   mem_ctrl_data_o     read byte for the address presented last cycle
//   ram_din             RAM read data (1-cycle latency)
//   ram_a/ram_dout      RAM address and write data
//   ram_wr              RAM write strobe
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_request,
  input  logic [31:0]       if_addr,
  input  logic [1:0]        mem_request,
  input  logic [31:0]       mem_addr,
  input  logic [7:0]        mem_ctrl_data_i,
  output logic [1:0]        if_or_mem,
  output logic [7:0]        mem_ctrl_data_o,
  input  logic [7:0]        ram_din,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    LOCK_IF  = 2'b01,
    LOCK_MEM = 2'b10
  } lock_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_MEM  = 2'b10;

  lock_e             lock_q, lock_d;
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;

  logic [1:0] owner;
  logic       mem_ld, mem_st, mem_req;

  // Address bits above the RAM width are intentionally dropped.
  logic addr_hi_unused;
  assign addr_hi_unused = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

  always_comb begin
    mem_ld  = (mem_request == 2'b01);
    mem_st  = (mem_request == 2'b10);
    mem_req = mem_ld | mem_st;

    owner  = OWN_NONE;
    lock_d = lock_q;

    // Owner is decided combinationally so the winner's first address reaches
    // the RAM in the very cycle the request appears. A locked owner that drops
    // its request yields a cycle with no owner while the lock returns to IDLE.
    case (lock_q)
      IDLE: begin
        if (mem_req) begin
          owner  = OWN_MEM;
          lock_d = LOCK_MEM;
        end else if (if_request) begin
          owner  = OWN_IF;
          lock_d = LOCK_IF;
        end
      end
      LOCK_IF: begin
        if (if_request) owner  = OWN_IF;
        else            lock_d = IDLE;
      end
      LOCK_MEM: begin
        if (mem_req) owner  = OWN_MEM;
        else         lock_d = IDLE;
      end
      default: lock_d = IDLE;
    endcase

    // Reset forces reset-valued outputs even in the cycle reset is sampled.
    if (rst) owner = OWN_NONE;

    // With no owner the RAM address holds so the RAM sees no spurious change.
    case (owner)
      OWN_IF:  ram_a_d = if_addr[ADDR_W-1:0];
      OWN_MEM: ram_a_d = mem_addr[ADDR_W-1:0];
      default: ram_a_d = ram_a_q;
    endcase
    if (rst) ram_a_d = '0;

    ram_wr   = (owner == OWN_MEM) && mem_st;
    ram_dout = ram_wr ? mem_ctrl_data_i : 8'h00;

    rd_pend_d = (owner == OWN_IF) || ((owner == OWN_MEM) && mem_ld);
  end

  assign if_or_mem       = owner;
  assign ram_a           = ram_a_d;
  // rd_pend covers the release cycle, so the final byte of a burst still returns.
  assign mem_ctrl_data_o = (rd_pend_q && !rst) ? ram_din : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q    <= IDLE;
      rd_pend_q <= 1'b0;
      ram_a_q   <= '0;
    end else begin
      lock_q    <= lock_d;
      rd_pend_q <= rd_pend_d;
      ram_a_q   <= ram_a_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - vector table and scoreboard bench for mem_ctrl
module tb_mem_ctrl;

  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_request;
  logic [31:0]       if_addr;
  logic [1:0]        mem_request;
  logic [31:0]       mem_addr;
  logic [7:0]        mem_ctrl_data_i;
  logic [1:0]        if_or_mem;
  logic [7:0]        mem_ctrl_data_o;
  logic [7:0]        ram_din;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_request      (if_request),
    .if_addr         (if_addr),
    .mem_request     (mem_request),
    .mem_addr        (mem_addr),
    .mem_ctrl_data_i (mem_ctrl_data_i),
    .if_or_mem       (if_or_mem),
    .mem_ctrl_data_o (mem_ctrl_data_o),
    .ram_din         (ram_din),
    .ram_a           (ram_a),
    .ram_dout        (ram_dout),
    .ram_wr          (ram_wr)
  );

  always #5 clk = ~clk;

  // Single-port RAM, read-first, one cycle read latency.
  logic [7:0] ram_mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_wr) ram_mem[ram_a] <= ram_dout;
    ram_din <= ram_mem[ram_a];
  end

  typedef struct {
    bit          rst;
    bit          ifr;
    logic [31:0] ia;
    logic [1:0]  mr;
    logic [31:0] ma;
    logic [7:0]  di;
    logic [1:0]  eo;
    logic [16:0] ea;
    bit          ew;
    logic [7:0]  ed;
    bit          rd;
    logic [7:0]  rb;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sb[$];
  int         errors = 0;
  int         checks = 0;

  function automatic vec_t mk(bit r, bit ifr, logic [31:0] ia, logic [1:0] mr,
                              logic [31:0] ma, logic [7:0] di, logic [1:0] eo,
                              logic [16:0] ea, bit ew, logic [7:0] ed, bit rd,
                              logic [7:0] rb);
    vec_t v;
    v.rst = r; v.ifr = ifr; v.ia = ia; v.mr = mr; v.ma = ma; v.di = di;
    v.eo = eo; v.ea = ea; v.ew = ew; v.ed = ed; v.rd = rd; v.rb = rb;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle, check combinational outputs and the read byte that the
  // scoreboard expects from the previous cycle, then queue this cycle's read.
  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] exp_d;
    @(posedge clk);
    #1;
    rst             = v.rst;
    if_request      = v.ifr;
    if_addr         = v.ia;
    mem_request     = v.mr;
    mem_addr        = v.ma;
    mem_ctrl_data_i = v.di;
    @(negedge clk);
    chk("if_or_mem", idx, {30'd0, if_or_mem}, {30'd0, v.eo});
    chk("ram_a",     idx, {15'd0, ram_a},     {15'd0, v.ea});
    chk("ram_wr",    idx, {31'd0, ram_wr},    {31'd0, v.ew});
    chk("ram_dout",  idx, {24'd0, ram_dout},  {24'd0, v.ed});
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_empty vec=%0d actual=%0h required=none", idx, mem_ctrl_data_o);
    end else begin
      exp_d = sb.pop_front();
      if (v.rst) exp_d = 8'h00;
      chk("data_o", idx, {24'd0, mem_ctrl_data_o}, {24'd0, exp_d});
    end
    sb.push_back(v.rd ? v.rb : 8'h00);
  endtask

  initial begin
    rst = 1'b1; if_request = 1'b0; if_addr = '0;
    mem_request = 2'b00; mem_addr = '0; mem_ctrl_data_i = '0;

    for (int i = 0; i < (1 << ADDR_W); i++) ram_mem[i] = 8'h00;
    ram_mem['h100] = 8'h13; ram_mem['h101] = 8'h05;
    ram_mem['h102] = 8'h00; ram_mem['h103] = 8'h00;
    ram_mem['h300] = 8'hA1; ram_mem['h301] = 8'hA2;
    ram_mem['h302] = 8'hA3; ram_mem['h303] = 8'hA4;
    ram_mem['h601] = 8'h99;
    for (int k = 0; k < 256; k++) ram_mem['h700 + k] = 8'(k) ^ 8'h5A;

    // r ifr ia mr ma di | eo ea ew ed rd rb
    tbl.push_back(mk(1,0,32'h0,2'd0,32'h0,8'h00, 2'd0,17'h000,0,8'h00,0,8'h00));
    tbl.push_back(mk(1,0,32'h0,2'd0,32'h0,8'h00, 2'd0,17'h000,0,8'h00,0,8'h00));
    tbl.push_back(mk(0,0,32'h0,2'd0,32'h0,8'h00, 2'd0,17'h000,0,8'h00,0,8'h00));
    // IF 4-byte fetch, last address with high bits set to exercise truncation
    tbl.push_back(mk(0,1,32'h100,2'd0,32'h0,8'h00, 2'd1,17'h100,0,8'h00,1,8'h13));
    tbl.push_back(mk(0,1,32'h101,2'd0,32'h0,8'h00, 2'd1,17'h101,0,8'h00,1,8'h05));
    tbl.push_back(mk(0,1,32'h102,2'd0,32'h0,8'h00, 2'd1,17'h102,0,8'h00,1,8'h00));
    tbl.push_back(mk(0,1,32'hFFFE0103,2'd0,32'h0,8'h00, 2'd1,17'h103,0,8'h00,1,8'h00));
    tbl.push_back(mk(0,0,32'h0,2'd0,32'h0,8'h00, 2'd0,17'h103,0,8'h00,0,8'h00));
    // MEM SW 0xDEADBEEF @0x200
    tbl.push_back(mk(0,0,32'h0,2'd2,32'h200,8'hEF, 2'd2,17'h200,1,8'hEF,0,8'h00));
    tbl.push_back(mk(0,0,32'h0,2'd2,32'h201,8'hBE, 2'd2,17'h201,1,8'hBE,0,8'h00));
    tbl.push_back(mk(0,0,32'h0,2'd2,32'h202,8'hAD, 2'd2,17'h202,1,8'hAD,0,8'h00));
    tbl.push_back(mk(0,0,32'h0,2'd2,32'h203,8'hDE, 2'd2,17'h203,1,8'hDE,0,8'h00));
    tbl.push_back(mk(0,0,32'h0,2'd0,32'h0,8'h00, 2'd0,17'h203,0,8'h00,0,8'h00));
    // MEM LW @0x200, store data held at 0x55 must not reach ram_dout
    tbl.push_back(mk(0,0,32'h0,2'd1,32'h200,8'h55, 2'd2,17'h200,0,8'h00,1,8'hEF));
    tbl.push_back(mk(0,0,32'h0,2'd1,32'h201,8'h55, 2'd2,17'h201,0,8'h00,1,8'hBE));
    tbl.push_back(mk(0,0,32'h0,2'd1,32'h202,8'h55, 2'd2,17'h202,0,8'h00,1,8'hAD));
    tbl.push_back(mk(0,0,32'h0,2'd1,32'h203,8'h55, 2'd2,17'h203,0,8'h00,1,8'hDE));
    tbl.push_back(mk(0,0,32'h0,2'd0,32'h0,8'h00, 2'd0,17'h203,0,8'h00,0,8'h00));
    // Simultaneous requests from IDLE: MEM wins, IF waits and is served after release
    tbl.push_back(mk(0,1,32'h300,2'd1,32'h100,8'h00, 2'd2,17'h100,0,8'h00,1,8'h13));
    tbl.push_back(mk(0,1,32'h300,2'd1,32'h101,8'h00, 2'd2,17'h101,0,8'h00,1,8'h05));
    tbl.push_back(mk(0,1,32'h300,2'd0,32'h0,8'h00, 2'd0,17'h101,0,8'h00,0,8'h00));
    tbl.push_back(mk(0,1,32'h300,2'd0,32'h0,8'h00, 2'd1,17'h300,0,8'h00,1,8'hA1));
    tbl.push_back(mk(0,1,32'h301,2'd0,32'h0,8'h00, 2'd1,17'h301,0,8'h00,1,8'hA2));
    tbl.push_back(mk(0,0,32'h0,2'd0,32'h0,8'h00, 2'd0,17'h301,0,8'h00,0,8'h00));
    // MEM store requested while IF locked: no write until IF releases
    tbl.push_back(mk(0,1,32'h302,2'd0,32'h0,8'h00, 2'd1,17'h302,0,8'h00,1,8'hA3));
    tbl.push_back(mk(0,1,32'h303,2'd2,32'h500,8'h77, 2'd1,17'h303,0,8'h00,1,8'hA4));
    tbl.push_back(mk(0,1,32'h300,2'd2,32'h500,8'h77, 2'd1,17'h300,0,8'h00,1,8'hA1));
    tbl.push_back(mk(0,0,32'h0,2'd2,32'h500,8'h77, 2'd0,17'h300,0,8'h00,0,8'h00));
    tbl.push_back(mk(0,0,32'h0,2'd2,32'h500,8'h77, 2'd2,17'h500,1,8'h77,0,8'h00));
    tbl.push_back(mk(0,0,32'h0,2'd1,32'h500,8'h00, 2'd2,17'h500,0,8'h00,1,8'h77));
    tbl.push_back(mk(0,0,32'h0,2'd0,32'h0,8'h00, 2'd0,17'h500,0,8'h00,0,8'h00));
    // Reset mid-SW after byte 1; byte 2 must never be written
    tbl.push_back(mk(0,0,32'h0,2'd2,32'h600,8'h11, 2'd2,17'h600,1,8'h11,0,8'h00));
    tbl.push_back(mk(1,0,32'h0,2'd2,32'h601,8'h22, 2'd0,17'h000,0,8'h00,0,8'h00));
    tbl.push_back(mk(0,0,32'h0,2'd0,32'h0,8'h00, 2'd0,17'h000,0,8'h00,0,8'h00));
    tbl.push_back(mk(0,1,32'h100,2'd0,32'h0,8'h00, 2'd1,17'h100,0,8'h00,1,8'h13));
    tbl.push_back(mk(0,0,32'h0,2'd0,32'h0,8'h00, 2'd0,17'h100,0,8'h00,0,8'h00));
    tbl.push_back(mk(0,0,32'h0,2'd1,32'h600,8'h00, 2'd2,17'h600,0,8'h00,1,8'h11));
    tbl.push_back(mk(0,0,32'h0,2'd1,32'h601,8'h00, 2'd2,17'h601,0,8'h00,1,8'h99));
    tbl.push_back(mk(0,0,32'h0,2'd0,32'h0,8'h00, 2'd0,17'h601,0,8'h00,0,8'h00));
    // mem_request=11 is no request
    tbl.push_back(mk(0,0,32'h0,2'd3,32'h700,8'hFF, 2'd0,17'h601,0,8'h00,0,8'h00));
    tbl.push_back(mk(0,0,32'h0,2'd0,32'h0,8'h00, 2'd0,17'h601,0,8'h00,0,8'h00));
    tbl.push_back(mk(0,1,32'h101,2'd3,32'h700,8'hFF, 2'd1,17'h101,0,8'h00,1,8'h05));
    tbl.push_back(mk(0,0,32'h0,2'd3,32'h700,8'hFF, 2'd0,17'h101,0,8'h00,0,8'h00));
    tbl.push_back(mk(0,0,32'h0,2'd0,32'h0,8'h00, 2'd0,17'h101,0,8'h00,0,8'h00));

    sb.push_back(8'h00);
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Hand-written burst: IF fetch of random addresses within 0x700..0x7FF.
    begin
      vec_t        v;
      logic [7:0]  off;
      logic [16:0] last_a;
      last_a = 17'h101;
      for (int n = 0; n < 8; n++) begin
        off    = 8'($urandom_range(0, 255));
        last_a = 17'h700 + {9'd0, off};
        v = mk(0,1,{15'd0, last_a},2'd0,32'h0,8'h00, 2'd1,last_a,0,8'h00,1,off ^ 8'h5A);
        run_vec(v, 100 + n);
      end
      v = mk(0,0,32'h0,2'd0,32'h0,8'h00, 2'd0,last_a,0,8'h00,0,8'h00);
      run_vec(v, 108);
      v = mk(0,0,32'h0,2'd0,32'h0,8'h00, 2'd0,last_a,0,8'h00,0,8'h00);
      run_vec(v, 109);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
